fifo_read_ctrl: RTL and testbench

Read-side controller for the team's 8x8 asynchronous FIFO; the consumer end of the Gray-pointer write path.
- Runs entirely in the rclk domain.
- Synchronises the Gray-coded write pointer through two flops and keeps the read pointer in binary and Gray form.
- Derives empty status and fill level.
- Presents memory data through a one-entry registered output stage with a valid/ready handshake.
- Returns its Gray read pointer to the write domain for full detection.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/ptr_sync_2ff.sv | 36 +++
 rtl/fifo_read_ctrl.sv | 89 ++++++++
 tb/tb_fifo_read_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8x8 asynchronous FIFO.
// Holds the default geometry and the Gray/binary pointer conversions used by
// both the read-side and write-side controllers.
package fifo_pkg;

  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_PTR_SIZE   = 3;

  // Pointers carry one extra wrap bit above the memory address.
  typedef logic [FIFO_PTR_SIZE:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[FIFO_PTR_SIZE] = g[FIFO_PTR_SIZE];
    for (int i = FIFO_PTR_SIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchroniser for Gray-coded pointers crossing clock domains.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low clear
//   d     - pointer from the source domain
//   q     - pointer after two destination flops
module ptr_sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1_q, q1_d;
  logic [WIDTH-1:0] q2_q, q2_d;

  always_comb begin
    q1_d = d;
    q2_d = q1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign q = q2_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous FIFO, entirely in the rclk domain.
// Synchronises the write pointer, tracks the read pointer (binary + Gray),
// derives empty/level and feeds a one-entry registered valid/ready output.
// Ports:
//   rclk, reset_n  - read clock, asynchronous active-low reset
//   wptr_gray      - Gray write pointer from the wclk domain
//   mem_raddr      - memory read address; mem_rdata is its combinational word
//   rptr_gray      - registered Gray read pointer back to the write domain
//   dout/dout_valid/dout_ready - output stage handshake
//   fifo_empty     - no unread word in memory
//   rd_level       - words in memory visible to the reader, 0..DEPTH
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PTR_SIZE   = FIFO_PTR_SIZE
) (
  input  logic                  rclk,
  input  logic                  reset_n,
  input  logic [PTR_SIZE:0]     wptr_gray,
  output logic [PTR_SIZE-1:0]   mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [PTR_SIZE:0]     rptr_gray,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  fifo_empty,
  output logic [PTR_SIZE:0]     rd_level
);

  localparam logic [PTR_SIZE-1:0] ADDR_MSK = PTR_SIZE'(DEPTH - 1);

  logic [PTR_SIZE:0]     wq2, wbin;
  logic [PTR_SIZE:0]     rbin_q, rbin_d;
  logic [PTR_SIZE:0]     rgray_q, rgray_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvld_q, dvld_d;
  logic                  load;

  // wptr_gray only reaches logic through the synchroniser.
  ptr_sync_2ff #(.WIDTH(PTR_SIZE + 1)) u_wptr_sync (
    .clk   (rclk),
    .rst_n (reset_n),
    .d     (wptr_gray),
    .q     (wq2)
  );

  always_comb begin
    wbin       = gray2bin(wq2);
    fifo_empty = (rgray_q == wq2);
    rd_level   = wbin - rbin_q;
    // Load whenever memory has a word and the stage is free or being drained.
    load       = !fifo_empty && (!dvld_q || dout_ready);

    rbin_d = rbin_q;
    dout_d = dout_q;
    dvld_d = dvld_q;
    if (load) begin
      rbin_d = rbin_q + 1'b1;
      dout_d = mem_rdata;
      dvld_d = 1'b1;
    end else if (dvld_q && dout_ready) begin
      dvld_d = 1'b0;
    end
    // Gray pointer registered from the next binary value: glitch-free to wclk.
    rgray_d = bin2gray(rbin_d);
  end

  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
    end
  end

  assign mem_raddr  = rbin_q[PTR_SIZE-1:0] & ADDR_MSK;
  assign rptr_gray  = rgray_q;
  assign dout       = dout_q;
  assign dout_valid = dvld_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

  logic       rclk = 1'b0;
  logic       reset_n;
  logic [3:0] wptr_gray;
  logic [2:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic [3:0] rptr_gray;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       fifo_empty;
  logic [3:0] rd_level;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mem [8];
  logic [7:0] hist [$];   // every word written since reset, in order
  int         wcnt;       // words written since reset

  fifo_read_ctrl dut (
    .rclk       (rclk),
    .reset_n    (reset_n),
    .wptr_gray  (wptr_gray),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .rptr_gray  (rptr_gray),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .fifo_empty (fifo_empty),
    .rd_level   (rd_level)
  );

  always #5 rclk = ~rclk;
  assign mem_rdata = mem[mem_raddr];

  always @(negedge rclk)
    if (reset_n === 1'b1 && rd_level > 4'd8) begin
      n_err++;
      $display("FAIL rd_level_bound: got %0d max 8", rd_level);
    end

  function automatic logic [3:0] gry(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  // Writer side: store in memory, then advance the Gray write pointer.
  task automatic push(input logic [7:0] d);
    mem[wcnt % 8] = d;
    hist.push_back(d);
    wcnt++;
    wptr_gray = gry(wcnt);
  endtask

  task automatic edges(input int n);
    repeat (n) begin @(posedge rclk); @(negedge rclk); end
  endtask

  task automatic do_reset();
    @(negedge rclk);
    reset_n = 1'b0; wcnt = 0; wptr_gray = 4'b0000; dout_ready = 1'b0;
    hist.delete();
    @(negedge rclk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wptr_gray = 4'b0101; dout_ready = 1'b1;
    #3;
    n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h exp 00", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", dout_valid); end
    n_cmp++; if (rptr_gray !== 4'b0000) begin n_err++; $display("FAIL rst_rptr: got %b exp 0000", rptr_gray); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b exp 1", fifo_empty); end
    n_cmp++; if (rd_level !== 4'd0) begin n_err++; $display("FAIL rst_level: got %0d exp 0", rd_level); end
    @(negedge rclk);
    reset_n = 1'b1;
    edges(1);
    n_cmp++; if (dout_valid !== 1'b0 || fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_noload1: got v=%b e=%b exp v=0 e=1", dout_valid, fifo_empty); end
    edges(1);
    n_cmp++; if (dout_valid !== 1'b0 || rd_level !== 4'd6) begin n_err++; $display("FAIL rst_noload2: got v=%b lvl=%0d exp v=0 lvl=6", dout_valid, rd_level); end
    edges(1);
    n_cmp++; if (dout_valid !== 1'b1 || dout !== mem[0]) begin n_err++; $display("FAIL rst_firstload: got v=%b d=%h exp v=1 d=%h", dout_valid, dout, mem[0]); end
  endtask

  task automatic test_latency();
    do_reset();
    push(8'hA5);
    edges(1);
    n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL lat_empty1: got %b exp 1", fifo_empty); end
    edges(1);
    n_cmp++; if (fifo_empty !== 1'b0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL lat_empty2: got e=%b v=%b exp e=0 v=0", fifo_empty, dout_valid); end
    edges(1);
    n_cmp++; if (dout !== 8'hA5 || dout_valid !== 1'b1) begin n_err++; $display("FAIL lat_load: got d=%h v=%b exp d=a5 v=1", dout, dout_valid); end
    n_cmp++; if (rptr_gray !== 4'b0001 || mem_raddr !== 3'd1) begin n_err++; $display("FAIL lat_ptr: got g=%b a=%0d exp g=0001 a=1", rptr_gray, mem_raddr); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL lat_empty3: got %b exp 1", fifo_empty); end
    edges(1);
    n_cmp++; if (dout !== 8'hA5 || dout_valid !== 1'b1) begin n_err++; $display("FAIL lat_hold: got d=%h v=%b exp d=a5 v=1", dout, dout_valid); end
  endtask

  task automatic test_backpressure();
    push(8'hB1);
    push(8'hC2);
    edges(3);
    n_cmp++; if (dout !== 8'hA5 || rptr_gray !== 4'b0001) begin n_err++; $display("FAIL bp_hold: got d=%h g=%b exp d=a5 g=0001", dout, rptr_gray); end
    n_cmp++; if (rd_level !== 4'd2) begin n_err++; $display("FAIL bp_level: got %0d exp 2", rd_level); end
    dout_ready = 1'b1;
    edges(1);
    n_cmp++; if (dout !== 8'hB1 || dout_valid !== 1'b1) begin n_err++; $display("FAIL bp_w2: got d=%h v=%b exp d=b1 v=1", dout, dout_valid); end
    edges(1);
    n_cmp++; if (dout !== 8'hC2 || dout_valid !== 1'b1) begin n_err++; $display("FAIL bp_w3: got d=%h v=%b exp d=c2 v=1", dout, dout_valid); end
    edges(1);
    n_cmp++; if (dout_valid !== 1'b0 || fifo_empty !== 1'b1 || rd_level !== 4'd0) begin n_err++; $display("FAIL bp_drain: got v=%b e=%b lvl=%0d exp v=0 e=1 lvl=0", dout_valid, fifo_empty, rd_level); end
    n_cmp++; if (rptr_gray !== 4'b0010) begin n_err++; $display("FAIL bp_rptr: got %b exp 0010", rptr_gray); end
  endtask

  task automatic test_full();
    do_reset();
    push(8'($urandom));
    edges(3);
    repeat (8) push(8'($urandom));
    edges(2);
    n_cmp++; if (rd_level !== 4'd8 || fifo_empty !== 1'b0) begin n_err++; $display("FAIL full_level: got lvl=%0d e=%b exp lvl=8 e=0", rd_level, fifo_empty); end
    edges(1);
    n_cmp++; if (dout !== hist[0] || rptr_gray !== 4'b0001) begin n_err++; $display("FAIL full_stable: got d=%h g=%b exp d=%h g=0001", dout, rptr_gray, hist[0]); end
    dout_ready = 1'b1;
    edges(1);
    dout_ready = 1'b0;
    n_cmp++; if (rd_level !== 4'd7 || dout !== hist[1]) begin n_err++; $display("FAIL full_consume: got lvl=%0d d=%h exp lvl=7 d=%h", rd_level, dout, hist[1]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) push(8'($urandom));
    edges(3);
    n_cmp++; if (dout_valid !== 1'b1 || rd_level !== 4'd4) begin n_err++; $display("FAIL mid_pre: got v=%b lvl=%0d exp v=1 lvl=4", dout_valid, rd_level); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin n_err++; $display("FAIL mid_out: got d=%h v=%b exp d=00 v=0", dout, dout_valid); end
    n_cmp++; if (rptr_gray !== 4'b0000 || mem_raddr !== 3'd0) begin n_err++; $display("FAIL mid_ptr: got g=%b a=%0d exp 0000/0", rptr_gray, mem_raddr); end
    n_cmp++; if (fifo_empty !== 1'b1 || rd_level !== 4'd0) begin n_err++; $display("FAIL mid_status: got e=%b lvl=%0d exp e=1 lvl=0", fifo_empty, rd_level); end
    @(negedge rclk);
    wcnt = 0; wptr_gray = 4'b0000; hist.delete();
    reset_n = 1'b1;
  endtask

  // Reference model in terms of word counts: words written, words visible
  // after the two-cycle sync delay, words taken into the output stage.
  task automatic run_model(input string name, input int ncyc, input bit rnd_ready,
                           input int wrate, input bit want_wrap);
    int vis_q1 = 0, vis = 0, n_ld = 0, n_out = 0;
    bit mvalid = 0, ld, gwrap = 0, awrap = 0;
    logic [3:0] prev_g = 4'b0000;
    logic [2:0] prev_a = 3'd0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (int'($urandom_range(0, 99)) < wrate && wcnt - n_ld < 8) push(8'($urandom));
      n_cmp++;
      if (dout_valid !== mvalid || rptr_gray !== gry(n_ld) || mem_raddr !== 3'(n_ld)
          || rd_level !== 4'(vis - n_ld) || fifo_empty !== (vis == n_ld)) begin
        n_err++;
        $display("FAIL %s_state c=%0d: got v=%b g=%b a=%0d lvl=%0d e=%b exp v=%b g=%b a=%0d lvl=%0d e=%b",
                 name, c, dout_valid, rptr_gray, mem_raddr, rd_level, fifo_empty,
                 mvalid, gry(n_ld), 3'(n_ld), 4'(vis - n_ld), vis == n_ld);
      end
      if (mvalid) begin
        n_cmp++;
        if (dout !== hist[n_ld-1]) begin
          n_err++; $display("FAIL %s_data c=%0d: got %h exp %h", name, c, dout, hist[n_ld-1]);
        end
        if (dout_ready) n_out++;
      end
      if (prev_g == 4'b1000 && rptr_gray == 4'b0000) gwrap = 1;
      if (prev_a == 3'd7 && mem_raddr == 3'd0) awrap = 1;
      prev_g = rptr_gray; prev_a = mem_raddr;
      @(posedge rclk);
      ld = (n_ld != vis) && (!mvalid || dout_ready);
      if (ld) begin n_ld++; mvalid = 1; end
      else if (mvalid && dout_ready) mvalid = 0;
      vis = vis_q1;
      vis_q1 = wcnt;
      @(negedge rclk);
    end
    if (want_wrap) begin
      n_cmp++;
      if (!gwrap || !awrap || n_out < 20) begin
        n_err++; $display("FAIL %s_wrap: got gwrap=%b awrap=%b words=%0d exp 1 1 >=20", name, gwrap, awrap, n_out);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    wcnt = 0;
    test_reset();
    test_latency();
    test_backpressure();
    test_full();
    test_reset_mid();
    run_model("wrap", 30, 1'b0, 100, 1'b1);
    run_model("rand", 400, 1'b1, 50, 1'b0);
    run_model("burst", 300, 1'b1, 85, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
